// File: rtl/img_feeder_pkg.sv
// Shared constants and state encoding for the image feeder.
// Default geometry is a 121-pixel, 8-bit image with a 32-bit result.
package img_feeder_pkg;

  localparam int N_PIX = 121;
  localparam int PIX_W = 8;
  localparam int RES_W = 32;

  localparam logic [RES_W-1:0] RES_TIMEOUT = '1;

  typedef enum logic [1:0] {
    LOAD,
    START,
    WAIT,
    RESULT
  } state_e;

endpackage

// File: rtl/wdog_counter.sv
// Response watchdog: counts enabled cycles from zero and flags
// the cycle in which the count reaches MAX-1.
module wdog_counter #(
  parameter int MAX = 65535
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic clr_i,
  input  logic en_i,
  output logic tc_o
);

  localparam int W = (MAX > 1) ? $clog2(MAX) : 1;

  logic [W-1:0] cnt_q;
  logic [W-1:0] cnt_d;

  // Clear wins over enable so every wait window starts from zero.
  always_comb begin
    cnt_d = cnt_q;
    if (clr_i)
      cnt_d = '0;
    else if (en_i)
      cnt_d = cnt_q + 1'b1;
  end

  // Count register.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i)
      cnt_q <= '0;
    else
      cnt_q <= cnt_d;
  end

  assign tc_o = en_i && (cnt_q == W'(MAX - 1));

endmodule

// File: rtl/img_feeder_121.sv
// Collects a full image pixel by pixel, starts the network, then
// returns its prediction (or all-ones on timeout) over a handshake.
module img_feeder_121 #(
  parameter int N_PIX    = img_feeder_pkg::N_PIX,
  parameter int PIX_W    = img_feeder_pkg::PIX_W,
  parameter int RES_W    = img_feeder_pkg::RES_W,
  parameter int WAIT_MAX = 65535
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [PIX_W-1:0]       pix_data,
  input  logic                   pix_valid,
  output logic                   pix_ready,
  output logic [N_PIX*PIX_W-1:0] img_source,
  output logic                   valid_top,
  input  logic                   ready_top,
  input  logic [RES_W-1:0]       number,
  output logic [RES_W-1:0]       res_data,
  output logic                   res_valid,
  input  logic                   res_ready,
  output logic                   timeout
);

  import img_feeder_pkg::*;

  localparam int CNT_W = (N_PIX > 1) ? $clog2(N_PIX) : 1;
  localparam logic [RES_W-1:0] RES_ONES = {RES_W{1'b1}};

  state_e                 state_q;
  logic [CNT_W-1:0]       pix_cnt_q;
  logic [N_PIX*PIX_W-1:0] img_q;
  logic                   vt_q;
  logic                   to_q;
  logic                   rv_q;
  logic [RES_W-1:0]       res_q;
  logic                   wd_tc;

  assign pix_ready = (state_q == LOAD);

  wdog_counter #(
    .MAX (WAIT_MAX)
  ) u_wdog (
    .clk_i (clk),
    .rst_i (rst),
    .clr_i (state_q != WAIT),
    .en_i  (state_q == WAIT),
    .tc_o  (wd_tc)
  );

  // Main FSM: pixel capture, start pulse, wait/timeout, result hold.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= LOAD;
      pix_cnt_q <= '0;
      img_q     <= '0;
      vt_q      <= 1'b0;
      to_q      <= 1'b0;
      rv_q      <= 1'b0;
      res_q     <= '0;
    end else begin
      vt_q <= 1'b0;
      to_q <= 1'b0;
      unique case (state_q)
        LOAD: begin
          if (pix_valid) begin
            for (int k = 0; k < N_PIX; k++)
              if (pix_cnt_q == CNT_W'(k))
                img_q[k*PIX_W +: PIX_W] <= pix_data;
            if (pix_cnt_q == CNT_W'(N_PIX - 1)) begin
              pix_cnt_q <= '0;
              state_q   <= START;
              vt_q      <= 1'b1;
            end else begin
              pix_cnt_q <= pix_cnt_q + 1'b1;
            end
          end
        end
        START: state_q <= WAIT;
        WAIT: begin
          if (ready_top) begin
            res_q   <= number;
            rv_q    <= 1'b1;
            state_q <= RESULT;
          end else if (wd_tc) begin
            res_q   <= RES_ONES;
            to_q    <= 1'b1;
            rv_q    <= 1'b1;
            state_q <= RESULT;
          end
        end
        RESULT: begin
          if (res_ready) begin
            rv_q    <= 1'b0;
            state_q <= LOAD;
          end
        end
        default: state_q <= LOAD;
      endcase
    end
  end

  assign img_source = img_q;
  assign valid_top  = vt_q;
  assign res_data   = res_q;
  assign res_valid  = rv_q;
  assign timeout    = to_q;

endmodule

// File: tb/tb_img_feeder_121.sv
// Scenario bench for img_feeder_121 with a short watchdog.
// Expected results are queued at stimulus time and popped on output.
module tb_img_feeder_121;

  localparam int NP = 121;
  localparam int PW = 8;
  localparam int RW = 32;
  localparam int WM = 16;

  logic             clk = 1'b0;
  logic             rst;
  logic [PW-1:0]    pix_data;
  logic             pix_valid;
  logic             pix_ready;
  logic [NP*PW-1:0] img_source;
  logic             valid_top;
  logic             ready_top;
  logic [RW-1:0]    number;
  logic [RW-1:0]    res_data;
  logic             res_valid;
  logic             res_ready;
  logic             timeout;

  int n_cmp = 0;
  int n_bad = 0;
  int vt_cnt = 0;
  int to_cnt = 0;
  logic [RW-1:0] sb_q[$];
  logic [RW-1:0] exp_v;

  img_feeder_121 #(
    .N_PIX    (NP),
    .PIX_W    (PW),
    .RES_W    (RW),
    .WAIT_MAX (WM)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .pix_data   (pix_data),
    .pix_valid  (pix_valid),
    .pix_ready  (pix_ready),
    .img_source (img_source),
    .valid_top  (valid_top),
    .ready_top  (ready_top),
    .number     (number),
    .res_data   (res_data),
    .res_valid  (res_valid),
    .res_ready  (res_ready),
    .timeout    (timeout)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (valid_top) vt_cnt <= vt_cnt + 1;
    if (timeout)   to_cnt <= to_cnt + 1;
  end

  function automatic logic [NP*PW-1:0] exp_img(input int base);
    logic [NP*PW-1:0] v;
    v = '0;
    for (int k = 0; k < NP; k++) v[k*PW +: PW] = PW'(base + k);
    return v;
  endfunction

  task automatic drive_image(input int base, input int cnt);
    for (int i = 0; i < cnt; i++) begin
      @(negedge clk);
      pix_data  = PW'(base + i);
      pix_valid = 1'b1;
    end
    @(negedge clk);
    pix_valid = 1'b0;
  endtask

  task automatic test_reset;
    rst = 1'b1; pix_valid = 1'b0; pix_data = '0;
    ready_top = 1'b0; number = '0; res_ready = 1'b0;
    repeat (2) @(negedge clk);
    n_cmp++; if (pix_ready !== 1'b1) begin n_bad++; $display("FAIL rst_pix_ready: got %b want 1", pix_ready); end
    n_cmp++; if (valid_top !== 1'b0) begin n_bad++; $display("FAIL rst_valid_top: got %b want 0", valid_top); end
    n_cmp++; if (res_valid !== 1'b0) begin n_bad++; $display("FAIL rst_res_valid: got %b want 0", res_valid); end
    n_cmp++; if (res_data !== '0) begin n_bad++; $display("FAIL rst_res_data: got %h want 0", res_data); end
    n_cmp++; if (timeout !== 1'b0) begin n_bad++; $display("FAIL rst_timeout: got %b want 0", timeout); end
    n_cmp++; if (img_source !== '0) begin n_bad++; $display("FAIL rst_img: got %h want 0", img_source); end
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_image_load;
    int v0;
    v0 = vt_cnt;
    drive_image(0, NP);
    n_cmp++; if (valid_top !== 1'b1) begin n_bad++; $display("FAIL load_vt_start: got %b want 1", valid_top); end
    n_cmp++; if (img_source[7:0] !== 8'h00) begin n_bad++; $display("FAIL load_pix0: got %h want 00", img_source[7:0]); end
    n_cmp++; if (img_source[967:960] !== 8'h78) begin n_bad++; $display("FAIL load_pix120: got %h want 78", img_source[967:960]); end
    n_cmp++; if (img_source !== exp_img(0)) begin n_bad++; $display("FAIL load_img: got %h want %h", img_source, exp_img(0)); end
    @(negedge clk);
    n_cmp++; if (valid_top !== 1'b0) begin n_bad++; $display("FAIL load_vt_width: got %b want 0", valid_top); end
    n_cmp++; if (vt_cnt !== v0 + 1) begin n_bad++; $display("FAIL load_vt_count: got %0d want %0d", vt_cnt, v0 + 1); end
    ready_top = 1'b1; number = 32'h11; res_ready = 1'b1;
    sb_q.push_back(32'h11);
    @(negedge clk);
    ready_top = 1'b0;
    n_cmp++; if (res_valid !== 1'b1) begin n_bad++; $display("FAIL best_latency: got %b want 1", res_valid); end
    exp_v = (sb_q.size() > 0) ? sb_q.pop_front() : 'x;
    n_cmp++; if (res_data !== exp_v) begin n_bad++; $display("FAIL best_res_data: got %h want %h", res_data, exp_v); end
    @(negedge clk);
    res_ready = 1'b0;
  endtask

  task automatic test_handshake;
    drive_image(8'h30, NP);
    @(negedge clk);
    @(negedge clk);
    ready_top = 1'b1; number = 32'd7; res_ready = 1'b1;
    sb_q.push_back(32'd7);
    @(negedge clk);
    ready_top = 1'b0; number = 32'hDEAD;
    n_cmp++; if (res_valid !== 1'b1) begin n_bad++; $display("FAIL hs_res_valid: got %b want 1", res_valid); end
    exp_v = (sb_q.size() > 0) ? sb_q.pop_front() : 'x;
    n_cmp++; if (res_data !== exp_v) begin n_bad++; $display("FAIL hs_res_data: got %h want %h", res_data, exp_v); end
    n_cmp++; if (timeout !== 1'b0) begin n_bad++; $display("FAIL hs_timeout: got %b want 0", timeout); end
    @(negedge clk);
    n_cmp++; if (res_valid !== 1'b0) begin n_bad++; $display("FAIL hs_res_valid_drop: got %b want 0", res_valid); end
    n_cmp++; if (pix_ready !== 1'b1) begin n_bad++; $display("FAIL hs_pix_ready: got %b want 1", pix_ready); end
    res_ready = 1'b0;
  endtask

  task automatic test_timeout;
    int to0;
    int lat;
    to0 = to_cnt;
    lat = 0;
    drive_image(8'h20, NP);
    res_ready = 1'b1;
    sb_q.push_back(32'hFFFF_FFFF);
    for (int i = 0; i < 40 && res_valid !== 1'b1; i++) begin
      @(negedge clk);
      lat++;
    end
    n_cmp++; if (res_valid !== 1'b1) begin n_bad++; $display("FAIL to_res_valid: got %b want 1 (wait bound expired)", res_valid); end
    n_cmp++; if (lat !== WM + 1) begin n_bad++; $display("FAIL to_latency: got %0d want %0d", lat, WM + 1); end
    exp_v = (sb_q.size() > 0) ? sb_q.pop_front() : 'x;
    n_cmp++; if (res_data !== exp_v) begin n_bad++; $display("FAIL to_res_data: got %h want %h", res_data, exp_v); end
    n_cmp++; if (timeout !== 1'b1) begin n_bad++; $display("FAIL to_pulse: got %b want 1", timeout); end
    @(negedge clk);
    n_cmp++; if (timeout !== 1'b0) begin n_bad++; $display("FAIL to_pulse_width: got %b want 0", timeout); end
    n_cmp++; if (to_cnt !== to0 + 1) begin n_bad++; $display("FAIL to_count: got %0d want %0d", to_cnt, to0 + 1); end
    n_cmp++; if (pix_ready !== 1'b1) begin n_bad++; $display("FAIL to_pix_ready: got %b want 1", pix_ready); end
    res_ready = 1'b0;
  endtask

  task automatic test_race;
    int to0;
    to0 = to_cnt;
    drive_image(8'h40, NP);
    repeat (WM) @(negedge clk);
    ready_top = 1'b1; number = 32'd3; res_ready = 1'b1;
    sb_q.push_back(32'd3);
    @(negedge clk);
    ready_top = 1'b0;
    n_cmp++; if (res_valid !== 1'b1) begin n_bad++; $display("FAIL race_res_valid: got %b want 1", res_valid); end
    exp_v = (sb_q.size() > 0) ? sb_q.pop_front() : 'x;
    n_cmp++; if (res_data !== exp_v) begin n_bad++; $display("FAIL race_res_data: got %h want %h", res_data, exp_v); end
    n_cmp++; if (timeout !== 1'b0) begin n_bad++; $display("FAIL race_timeout: got %b want 0", timeout); end
    @(negedge clk);
    n_cmp++; if (to_cnt !== to0) begin n_bad++; $display("FAIL race_to_count: got %0d want %0d", to_cnt, to0); end
    res_ready = 1'b0;
  endtask

  task automatic test_backpressure;
    drive_image(8'h60, NP);
    @(negedge clk);
    ready_top = 1'b1; number = 32'h5A; res_ready = 1'b0;
    sb_q.push_back(32'h5A);
    @(negedge clk);
    ready_top = 1'b0;
    pix_valid = 1'b1; pix_data = 8'hEE;
    for (int i = 0; i < 10; i++) begin
      n_cmp++; if (res_valid !== 1'b1) begin n_bad++; $display("FAIL bp_res_valid[%0d]: got %b want 1", i, res_valid); end
      n_cmp++; if (res_data !== 32'h5A) begin n_bad++; $display("FAIL bp_res_data[%0d]: got %h want 5a", i, res_data); end
      n_cmp++; if (pix_ready !== 1'b0) begin n_bad++; $display("FAIL bp_pix_ready[%0d]: got %b want 0", i, pix_ready); end
      @(negedge clk);
    end
    n_cmp++; if (img_source !== exp_img(8'h60)) begin n_bad++; $display("FAIL bp_img: got %h want %h", img_source, exp_img(8'h60)); end
    pix_valid = 1'b0;
    res_ready = 1'b1;
    exp_v = (sb_q.size() > 0) ? sb_q.pop_front() : 'x;
    n_cmp++; if (res_data !== exp_v) begin n_bad++; $display("FAIL bp_res_pop: got %h want %h", res_data, exp_v); end
    @(negedge clk);
    n_cmp++; if (res_valid !== 1'b0) begin n_bad++; $display("FAIL bp_release: got %b want 0", res_valid); end
    n_cmp++; if (pix_ready !== 1'b1) begin n_bad++; $display("FAIL bp_pix_ready_after: got %b want 1", pix_ready); end
    res_ready = 1'b0;
  endtask

  task automatic test_reset_mid;
    int v0;
    int rv_seen;
    rv_seen = 0;
    drive_image(8'h80, 60);
    v0 = vt_cnt;
    rst = 1'b1;
    @(negedge clk);
    n_cmp++; if (pix_ready !== 1'b1) begin n_bad++; $display("FAIL mid_rst_pix_ready: got %b want 1", pix_ready); end
    n_cmp++; if (img_source !== '0) begin n_bad++; $display("FAIL mid_rst_img: got %h want 0", img_source); end
    rst = 1'b0;
    drive_image(8'h10, NP);
    n_cmp++; if (img_source[7:0] !== 8'h10) begin n_bad++; $display("FAIL mid_slot0: got %h want 10", img_source[7:0]); end
    n_cmp++; if (img_source !== exp_img(8'h10)) begin n_bad++; $display("FAIL mid_img: got %h want %h", img_source, exp_img(8'h10)); end
    @(negedge clk);
    n_cmp++; if (vt_cnt !== v0 + 1) begin n_bad++; $display("FAIL mid_vt_count: got %0d want %0d", vt_cnt, v0 + 1); end
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    ready_top = 1'b1; number = 32'd9;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (res_valid === 1'b1) rv_seen++;
    end
    ready_top = 1'b0;
    n_cmp++; if (rv_seen !== 0) begin n_bad++; $display("FAIL mid_wait_rst_res_valid: got %0d want 0", rv_seen); end
    n_cmp++; if (vt_cnt !== v0 + 1) begin n_bad++; $display("FAIL mid_wait_rst_vt: got %0d want %0d", vt_cnt, v0 + 1); end
    n_cmp++; if (sb_q.size() !== 0) begin n_bad++; $display("FAIL sb_leftover: got %0d want 0", sb_q.size()); end
  endtask

  initial begin
    #500us;
    $display("FAIL global_time_limit: simulation did not complete");
    $fatal(1, "time limit");
  end

  initial begin
    test_reset();
    test_image_load();
    test_handshake();
    test_timeout();
    test_race();
    test_backpressure();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
